// File: rtl/common_types_pkg.sv
// Shared AHB slave types and timer register map.
// AHB_TIMER_PRESCALE_EN decides whether the PRESCALE offset decodes as mapped.
package common_types_pkg;

  localparam logic [31:0] TMR_CTRL     = 32'h00;
  localparam logic [31:0] TMR_PRESCALE = 32'h04;
  localparam logic [31:0] TMR_COUNT    = 32'h08;
  localparam logic [31:0] TMR_COMPARE  = 32'h0C;
  localparam logic [31:0] TMR_STATUS   = 32'h10;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} ahb_slave_state_t;

  function automatic logic is_mapped(input logic [31:0] off);
    case (off)
      TMR_CTRL, TMR_COUNT, TMR_COMPARE, TMR_STATUS: return 1'b1;
`ifdef AHB_TIMER_PRESCALE_EN
      TMR_PRESCALE: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_timer_if.sv
// AHB-Lite signal bundle between the bus multiplexor and the timer slave.
interface ahb_timer_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hrdata, hreadyout, hresp
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_timer_prescaler.sv
// Prescale divider: one tick every PRESCALE+1 enabled cycles.
// Only built when AHB_TIMER_PRESCALE_EN is defined.
`ifdef AHB_TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        clear,
  output logic        tick
);
  logic [15:0] r_pcnt;

  assign tick = en & (r_pcnt == prescale);

  // Disabling the timer parks the divider at 0 so re-enabling starts a fresh period.
  always_ff @(posedge clk) begin
    if (rst || clear || !en) r_pcnt <= '0;
    else if (tick)           r_pcnt <= '0;
    else                     r_pcnt <= r_pcnt + 16'd1;
  end
endmodule
`endif

// File: rtl/ahb_timer.sv
// AHB-Lite timer slave: CTRL/PRESCALE/COUNT/COMPARE/STATUS, compare match and irq.
// AHB_TIMER_PRESCALE_EN adds the prescaler; without it the counter ticks every enabled cycle.
module ahb_timer
  import common_types_pkg::*;
#(
  parameter logic [31:0] BASE_MASK = 32'h0000_00FF
) (
  input  logic        clk,
  input  logic        rst,
  ahb_timer_if.slave  bus,
  output logic        irq
);

  ahb_slave_state_t r_state, w_state_nxt;
  logic [31:0] r_off;
  logic        r_write;
  logic [2:0]  r_ctrl;
  logic [31:0] r_count, r_compare;
  logic        r_match, r_irq;

  logic [31:0] w_off, w_rd_val, w_count_nxt;
  logic        w_accept, w_legal, w_wr, w_tick, w_hit, w_match_nxt;
  logic        w_unused;

  assign w_off    = bus.haddr & BASE_MASK;
  assign w_accept = bus.hsel & bus.htrans[1] & bus.hready;
  assign w_legal  = is_mapped(w_off) && (bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] == 2'b00);
  assign w_wr     = (r_state == DATA) && r_write;
  assign w_unused = ^bus.hburst;
  assign irq      = r_irq;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // ERR2 deliberately ignores new accepts: the master must go idle after ERROR.
  always_comb begin
    w_state_nxt   = IDLE;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = '0;
    case (r_state)
      IDLE, DATA: if (w_accept) w_state_nxt = w_legal ? DATA : ERR1;
      ERR1: begin
        w_state_nxt   = ERR2;
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
      end
      ERR2:    bus.hresp = 1'b1;
      default: ;
    endcase
    if (r_state == DATA && !r_write) bus.hrdata = w_rd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_off   <= '0;
      r_write <= 1'b0;
    end else if (w_state_nxt == DATA) begin
      r_off   <= w_off;
      r_write <= bus.hwrite;
    end
  end

`ifdef AHB_TIMER_PRESCALE_EN
  logic [15:0] r_prescale;

  timer_prescaler u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (r_ctrl[CTRL_EN]),
    .prescale (r_prescale),
    .clear    (w_wr && (r_off == TMR_PRESCALE)),
    .tick     (w_tick)
  );
`else
  assign w_tick = r_ctrl[CTRL_EN];
`endif

  always_comb begin
    w_rd_val = '0;
    case (r_off)
      TMR_CTRL:     w_rd_val = {29'd0, r_ctrl};
`ifdef AHB_TIMER_PRESCALE_EN
      TMR_PRESCALE: w_rd_val = {16'd0, r_prescale};
`endif
      TMR_COUNT:    w_rd_val = r_count;
      TMR_COMPARE:  w_rd_val = r_compare;
      TMR_STATUS:   w_rd_val = {31'd0, r_match};
      default:      w_rd_val = '0;
    endcase
  end

  assign w_hit = w_tick && (r_count == r_compare);

  // Bus write to COUNT wins over a tick; a fresh match wins over a W1C.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && (r_off == TMR_COUNT))             w_count_nxt = bus.hwdata;
    else if (w_hit && r_ctrl[CTRL_AUTORELOAD])    w_count_nxt = '0;
    else if (w_tick)                              w_count_nxt = r_count + 32'd1;

    w_match_nxt = r_match;
    if (w_hit)                                                   w_match_nxt = 1'b1;
    else if (w_wr && (r_off == TMR_STATUS) && bus.hwdata[0])     w_match_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_match   <= 1'b0;
      r_irq     <= 1'b0;
`ifdef AHB_TIMER_PRESCALE_EN
      r_prescale <= '0;
`endif
    end else begin
      r_count <= w_count_nxt;
      r_match <= w_match_nxt;
      r_irq   <= w_match_nxt & r_ctrl[CTRL_IRQEN];
      if (w_wr) begin
        case (r_off)
          TMR_CTRL:     r_ctrl    <= bus.hwdata[2:0];
          TMR_COMPARE:  r_compare <= bus.hwdata;
`ifdef AHB_TIMER_PRESCALE_EN
          TMR_PRESCALE: r_prescale <= bus.hwdata[15:0];
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
